// File: rtl/pipe_hazard_if.sv
// Hazard-control bundle between the pipeline datapath/decoder and the
// hazard controller. The datapath side (master) presents read-stage operand
// usage and r1/execute status; the controller side (slave) returns the
// halt, flush, bubble and stall controls.
interface pipe_hazard_if;
  // Read-stage operand usage
  logic [2:0] id_src_a;
  logic [2:0] id_src_b;
  logic       id_use_a;
  logic       id_use_b;
  // r1 (read->execute register) contents and execute/memory status
  logic [2:0] r1_destination;
  logic       r1_is_load;
  logic       r1_is_halt;
  logic       ex_jump_taken;
  logic       mem_ready;
  // Pipeline controls
  logic       r2_pc_halt;
  logic       r2_pc_flush;
  logic       bubble;
  logic       pc_stall;
  logic       core_halted;

  modport master (
    output id_src_a, id_src_b, id_use_a, id_use_b,
    output r1_destination, r1_is_load, r1_is_halt, ex_jump_taken, mem_ready,
    input  r2_pc_halt, r2_pc_flush, bubble, pc_stall, core_halted
  );

  modport slave (
    input  id_src_a, id_src_b, id_use_a, id_use_b,
    input  r1_destination, r1_is_load, r1_is_halt, ex_jump_taken, mem_ready,
    output r2_pc_halt, r2_pc_flush, bubble, pc_stall, core_halted
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard / sequencing controller.
// Drives halt, flush and bubble for the read->execute register (r1) and the
// execute->writeback stage (r2), plus the fetch stall. Handles load-use
// hazards, slow data memory, taken-jump flushes and the HALT instruction.
// Optional feature: define PIPE_HAZARD_PERF_CNT_EN to add the saturating
// stall_cnt / flush_cnt performance counters (ports absent otherwise).
module pipe_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,   // cycles r2_pc_flush stays high per taken jump (1..7)
  parameter int CNT_W        = 16   // perf counter width
) (
  input  logic           clk,
  input  logic           rst_n,
  pipe_hazard_if.slave   hz
`ifdef PIPE_HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_FLUSH    = 2'd2;
  localparam logic [1:0] ST_HALTED   = 2'd3;

  // Remaining flush cycles after the jump cycle itself
  localparam logic [2:0] FLUSH_INIT  = 3'(FLUSH_CYCLES - 1);
  // A single-cycle flush is covered entirely by the jump cycle in RUN
  localparam bit         MULTI_FLUSH = (FLUSH_CYCLES > 1);

  logic [1:0] state_reg;
  logic [1:0] state_next;
  logic [2:0] flush_left_reg;
  logic [2:0] flush_left_next;

  logic halt_o;
  logic flush_o;
  logic bubble_o;
  logic halted_o;
  logic jump_accept;

  logic src_a_hit;
  logic src_b_hit;
  logic load_use;
  logic mem_busy;

  // Operand match against the load in r1; register 0 is not special
  assign src_a_hit = hz.id_use_a && (hz.id_src_a == hz.r1_destination);
  assign src_b_hit = hz.id_use_b && (hz.id_src_b == hz.r1_destination);
  assign load_use  = hz.r1_is_load && (src_a_hit || src_b_hit);
  assign mem_busy  = hz.r1_is_load && !hz.mem_ready;

  // Next-state and output decode; priority HALTED > MEM_WAIT > HALT > jump > load-use
  always_comb begin
    state_next      = state_reg;
    flush_left_next = flush_left_reg;
    halt_o          = 1'b0;
    flush_o         = 1'b0;
    bubble_o        = 1'b0;
    halted_o        = 1'b0;
    jump_accept     = 1'b0;

    case (state_reg)
      ST_RUN: begin
        if (hz.r1_is_halt) begin
          // Kill the younger instructions behind HALT, then stop
          flush_o    = 1'b1;
          state_next = ST_HALTED;
        end else if (mem_busy) begin
          // Load cannot complete this cycle: freeze everything
          halt_o     = 1'b1;
          state_next = ST_MEM_WAIT;
        end else if (hz.ex_jump_taken) begin
          flush_o     = 1'b1;
          jump_accept = 1'b1;
          if (MULTI_FLUSH) begin
            state_next      = ST_FLUSH;
            flush_left_next = FLUSH_INIT;
          end
        end else if (load_use) begin
          // Dependent instruction waits one cycle for the load result
          bubble_o = 1'b1;
        end
      end

      ST_MEM_WAIT: begin
        // r1 is frozen; jump/load-use are re-evaluated once back in RUN
        if (hz.mem_ready) begin
          state_next = ST_RUN;
        end else begin
          halt_o = 1'b1;
        end
      end

      ST_FLUSH: begin
        // r1 holds a flushed NOP here, so only jumps and the countdown matter
        flush_o = 1'b1;
        if (hz.ex_jump_taken) begin
          jump_accept     = 1'b1;
          flush_left_next = FLUSH_INIT;
        end else if (flush_left_reg <= 3'd1) begin
          state_next      = ST_RUN;
          flush_left_next = 3'd0;
        end else begin
          flush_left_next = flush_left_reg - 3'd1;
        end
      end

      ST_HALTED: begin
        // Sticky until reset
        halt_o   = 1'b1;
        halted_o = 1'b1;
      end

      default: begin
        state_next      = ST_RUN;
        flush_left_next = 3'd0;
      end
    endcase
  end

  // State and flush countdown registers; reset discards any pending wait/flush
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= ST_RUN;
      flush_left_reg <= 3'd0;
    end else begin
      state_reg      <= state_next;
      flush_left_reg <= flush_left_next;
    end
  end

  assign hz.r2_pc_halt  = halt_o;
  assign hz.r2_pc_flush = flush_o;
  assign hz.bubble      = bubble_o;
  assign hz.pc_stall    = halt_o | bubble_o;
  assign hz.core_halted = halted_o;

`ifdef PIPE_HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_reg;
  logic [CNT_W-1:0] flush_cnt_reg;

  // Saturating counters of stalled cycles and accepted taken jumps
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if ((halt_o || bubble_o) && (stall_cnt_reg != {CNT_W{1'b1}})) begin
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      end
      if (jump_accept && (flush_cnt_reg != {CNT_W{1'b1}})) begin
        flush_cnt_reg <= flush_cnt_reg + 1'b1;
      end
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a stimulus process drives one
// vector per cycle and pushes the reference model's expected outputs; a
// monitor on the falling edge pops and compares.
module tb_pipe_hazard_ctrl;
  localparam int FC = 2;
`ifdef PIPE_HAZARD_PERF_CNT_EN
  localparam int CW = 4;
`else
  localparam int CW = 16;
`endif
  localparam int unsigned CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipe_hazard_if hz();
`ifdef PIPE_HAZARD_PERF_CNT_EN
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;
`endif

  pipe_hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz.slave)
`ifdef PIPE_HAZARD_PERF_CNT_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  typedef struct {
    logic [4:0]  outs;   // {halt, flush, bubble, pc_stall, core_halted}
    int unsigned sc;
    int unsigned fc;
    int          tag;
  } exp_t;

  exp_t sb_q[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference model: pipeline mode flags plus remaining flush cycles
  bit          m_halted = 0;
  bit          m_wait   = 0;
  int          m_left   = 0;
  int unsigned m_sc     = 0;
  int unsigned m_fc     = 0;
  int          cur_tag  = 0;

  task automatic step(input bit rst, input bit [2:0] sa, input bit [2:0] sb,
                      input bit ua, input bit ub, input bit [2:0] dst,
                      input bit ld, input bit hl, input bit jp, input bit mr);
    exp_t e;
    bit h, f, b, ch, acc, n_halted, n_wait;
    int n_left;
    h = 0; f = 0; b = 0; ch = 0; acc = 0;
    n_halted = m_halted; n_wait = m_wait; n_left = m_left;

    rst_n                = !rst;
    hz.id_src_a          = sa;
    hz.id_src_b          = sb;
    hz.id_use_a          = ua;
    hz.id_use_b          = ub;
    hz.r1_destination    = dst;
    hz.r1_is_load        = ld;
    hz.r1_is_halt        = hl;
    hz.ex_jump_taken     = jp;
    hz.mem_ready         = mr;

    if (m_halted) begin
      h = 1; ch = 1;
    end else if (m_wait) begin
      h = !mr;
      n_wait = !mr;
    end else if (m_left > 0) begin
      f = 1;
      if (jp) begin acc = 1; n_left = FC - 1; end
      else n_left = m_left - 1;
    end else begin
      if (hl) begin f = 1; n_halted = 1; end
      else if (ld && !mr) begin h = 1; n_wait = 1; end
      else if (jp) begin f = 1; acc = 1; n_left = FC - 1; end
      else if (ld && ((ua && sa == dst) || (ub && sb == dst))) b = 1;
    end

    e.outs = {h, f, b, h | b, ch};
    e.sc   = m_sc;
    e.fc   = m_fc;
    e.tag  = cur_tag;
    sb_q.push_back(e);

    if (rst) begin
      m_halted = 0; m_wait = 0; m_left = 0; m_sc = 0; m_fc = 0;
    end else begin
      m_halted = n_halted; m_wait = n_wait; m_left = n_left;
      if ((h || b) && m_sc < CNT_MAX) m_sc++;
      if (acc && m_fc < CNT_MAX) m_fc++;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compare DUT outputs against the oldest expectation
  exp_t        mon_e;
  logic [4:0]  mon_act;
  bit          mon_bad;
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e   = sb_q.pop_front();
      mon_act = {hz.r2_pc_halt, hz.r2_pc_flush, hz.bubble, hz.pc_stall, hz.core_halted};
      mon_bad = (mon_act !== mon_e.outs);
`ifdef PIPE_HAZARD_PERF_CNT_EN
      if (stall_cnt !== CW'(mon_e.sc) || flush_cnt !== CW'(mon_e.fc)) mon_bad = 1;
      if (mon_bad)
        $display("FAIL ctrl_vec test=%0d t=%0t outs(halt,flush,bub,stall,hlt) got=%b want=%b stall_cnt got=%0d want=%0d flush_cnt got=%0d want=%0d",
                 mon_e.tag, $time, mon_act, mon_e.outs, stall_cnt, mon_e.sc, flush_cnt, mon_e.fc);
`else
      if (mon_bad)
        $display("FAIL ctrl_vec test=%0d t=%0t outs(halt,flush,bub,stall,hlt) got=%b want=%b",
                 mon_e.tag, $time, mon_act, mon_e.outs);
`endif
      vectors++;
      if (mon_bad) miscompares++;
    end
  end

  initial begin
    bit rst, ld, hl, jp, mr, ua, ub;
    bit [2:0] dst, sa, sb;
    int halted_for;

    // 1. Reset held three cycles with idle inputs
    rst_n = 0;
    hz.id_src_a = 0; hz.id_src_b = 0; hz.id_use_a = 0; hz.id_use_b = 0;
    hz.r1_destination = 0; hz.r1_is_load = 0; hz.r1_is_halt = 0;
    hz.ex_jump_taken = 0; hz.mem_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    cur_tag = 1;
    idle(3);

    // 2. Load-use on src A (match then no match), and on src B with register 0
    cur_tag = 2;
    step(0, 3, 0, 1, 0, 3, 1, 0, 0, 1);
    step(0, 4, 0, 1, 0, 3, 1, 0, 0, 1);
    step(0, 5, 0, 1, 1, 0, 1, 0, 0, 1);
    step(0, 5, 0, 0, 0, 0, 1, 0, 0, 1);
    idle(1);

    // 3. Slow memory: four not-ready cycles then ready
    cur_tag = 3;
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 2, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 2, 1, 0, 0, 1);
    idle(2);

    // 4. Jump pulse, then a second pulse inside the flush window
    cur_tag = 4;
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(3);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(3);

    // 5. HALT, long enough to saturate the stall counter, then reset
    cur_tag = 5;
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(20);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);

    // Randomized traffic, r1 kept as NOP during flush windows
    cur_tag = 6;
    halted_for = 0;
    for (int i = 0; i < 1500; i++) begin
      halted_for = m_halted ? halted_for + 1 : 0;
      rst = ($urandom_range(0, 99) == 0) || (halted_for > $urandom_range(2, 8));
      dst = 3'($urandom);
      sa  = $urandom_range(0, 1) ? dst : 3'($urandom);
      sb  = $urandom_range(0, 1) ? dst : 3'($urandom);
      ua  = 1'($urandom);
      ub  = 1'($urandom);
      ld  = (m_left > 0) ? 1'b0 : ($urandom_range(0, 99) < 40);
      hl  = (m_left > 0 || m_wait) ? 1'b0 : ($urandom_range(0, 99) < 3);
      jp  = ($urandom_range(0, 99) < 12);
      mr  = ($urandom_range(0, 99) < 55);
      step(rst, sa, sb, ua, ub, dst, ld, hl, jp, mr);
    end

    // Drain the scoreboard with a bounded wait
    repeat (3) @(negedge clk);
    if (sb_q.size() != 0) begin
      $display("FAIL drain got=%0d pending want=0", sb_q.size());
      miscompares++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global time limit
  initial begin
    #500000;
    $display("FAIL timeout got=%0d vectors want=completion", vectors);
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
